// File: rtl/bus_pkg.sv
// Shared definitions for the register-transfer bus initiator: state encoding,
// accumulator index and the one-hot select decoder used for dump and load.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      LATCH   = 3'd2,
      RELEASE = 3'd3,
      ERR     = 3'd4
   } xfer_state_e;

   localparam int ACC_IDX  = 0;
   localparam int MAX_REGS = 8;

   // Indices at or beyond n decode to all-zero, so an out-of-range select never strobes.
   function automatic logic [MAX_REGS-1:0] onehot(input int idx, input int n);
      logic [MAX_REGS-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_REGS; i++) r[i] = (i == idx) && (i < n);
      return r;
   endfunction

endpackage

// File: rtl/xfer_settle_cnt.sv
// Loadable down-counter with zero flag; times how long the source drives the
// bus before the destination is allowed to latch.
module xfer_settle_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         cnt_q <= '0;
      else if (load_i)                 cnt_q <= val_i;
      else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Initiator for the shared register-transfer bus: accepts one src->dst command,
// then sequences dump (drive), settle, load (latch) and release.
module bus_xfer_ctrl
   import bus_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = 2,
   parameter int SETTLE   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [SEL_W-1:0]    cmd_src,
   input  logic [SEL_W-1:0]    cmd_dst,
   input  logic                cmd_ext,
   output logic [NUM_REGS-1:0] dump,
   output logic [NUM_REGS-1:0] load,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

   xfer_state_e         state_q, state_d;
   logic [SEL_W-1:0]    dst_q, dst_d;
   logic [NUM_REGS-1:0] dump_q, dump_d, load_q, load_d;
   logic                done_q, done_d, err_q, err_d;
   logic                cnt_load, cnt_dec, cnt_zero;
   logic [MAX_REGS-1:0] oh_src, oh_dst;
   logic                accept, reject;

   assign oh_src    = onehot(int'(cmd_src), NUM_REGS);
   assign oh_dst    = onehot(int'(dst_q), NUM_REGS);
   assign cmd_ready = (state_q == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign reject    = (int'(cmd_dst) >= NUM_REGS) ||
                      (!cmd_ext && ((int'(cmd_src) >= NUM_REGS) || (cmd_src == cmd_dst)));

   xfer_settle_cnt #(.W(4)) u_settle (
      .clk    (clk),
      .rst    (reset),
      .load_i (cnt_load),
      .val_i  (SETTLE_INIT),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   // dump_q carries the captured source through DRIVE and LATCH, so no src register is kept.
   always_comb begin
      state_d  = state_q;
      dst_d    = dst_q;
      dump_d   = dump_q;
      load_d   = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (reject) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d  = DRIVE;
                  dst_d    = cmd_dst;
                  dump_d   = cmd_ext ? '0 : oh_src[NUM_REGS-1:0];
                  cnt_load = 1'b1;
               end
            end
         end
         DRIVE: begin
            if (cnt_zero) begin
               state_d = LATCH;
               load_d  = oh_dst[NUM_REGS-1:0];
            end else begin
               cnt_dec = 1'b1;
            end
         end
         LATCH: begin
            state_d = RELEASE;
            dump_d  = '0;
            done_d  = 1'b1;
         end
         RELEASE: state_d = IDLE;
         ERR:     state_d = IDLE;
         default: begin
            state_d = IDLE;
            dump_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dst_q   <= '0;
         dump_q  <= '0;
         load_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         dump_q  <= dump_d;
         load_q  <= load_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign dump = dump_q;
   assign load = load_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = (state_q != IDLE);

endmodule
